// File: rtl/fisc_fetch_unit_if.sv
// Fetch-unit bundle: memory read channel a, decode-side instruction
// handshake and the flow-control/redirect inputs. The master modport is the
// fetch unit itself; the slave modport is the memory/decode environment.
interface fisc_fetch_unit_if #(
    parameter int INTEGER_SZ     = 64,
    parameter int INSTRUCTION_SZ = 32,
    parameter int ADDR_SZ        = 16
);
    logic                      wait_n;
    logic                      redirect;
    logic [INTEGER_SZ-1:0]     redirect_pc;

    logic                      rd_a;
    logic [ADDR_SZ-1:0]        addr_bus_a;
    logic [INTEGER_SZ-1:0]     din_bus_a;

    logic                      instr_valid;
    logic                      instr_ready;
    logic [INSTRUCTION_SZ-1:0] instr;
    logic [INTEGER_SZ-1:0]     instr_pc;

    modport master (
        input  wait_n, redirect, redirect_pc, din_bus_a, instr_ready,
        output rd_a, addr_bus_a, instr_valid, instr, instr_pc
    );

    modport slave (
        output wait_n, redirect, redirect_pc, din_bus_a, instr_ready,
        input  rd_a, addr_bus_a, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fisc_fetch_unit.sv
// FISC instruction fetch stage. Reads one 64-bit block per memory access,
// hands its two 32-bit instructions to decode over valid/ready, and accepts
// PC redirects from the core. All outputs are registered.
module fisc_fetch_unit #(
    parameter int                INTEGER_SZ     = 64,
    parameter int                INSTRUCTION_SZ = 32,
    parameter int                ADDR_SZ        = 16,
    parameter int                RD_LATENCY     = 1,   // legal range 1..7
    parameter logic [INTEGER_SZ-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    fisc_fetch_unit_if.master bus
);
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HAVE = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [INTEGER_SZ-1:0]     pc_reg, pc_next;
    // Only the upper half of a block is ever needed after the latch cycle
    // (the lower half is presented directly from din_bus_a), so only it is kept.
    logic [INSTRUCTION_SZ-1:0] block_hi_reg, block_hi_next;
    logic [2:0]                cnt_reg, cnt_next;
    logic                      rd_reg, rd_next;
    logic [ADDR_SZ-1:0]        addr_reg, addr_next;
    logic                      valid_reg, valid_next;
    logic [INSTRUCTION_SZ-1:0] instr_reg, instr_next;
    logic [INTEGER_SZ-1:0]     instr_pc_reg, instr_pc_next;

    logic xfer;
    logic data_here;
    logic unused_redirect_lsbs;

    assign xfer      = valid_reg & bus.instr_ready & bus.wait_n;
    assign data_here = (state_reg == ST_WAIT) && (cnt_reg == 3'd0);

    // The low two redirect bits are discarded: instructions are word aligned.
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_REQ;
        else          state_reg <= state_next;
    end

    // Next-state logic; redirect restarts the fetch from REQ in every state
    always_comb begin
        state_next = state_reg;
        if (bus.redirect) begin
            state_next = ST_REQ;
        end else begin
            case (state_reg)
                ST_REQ:  if (bus.wait_n)         state_next = ST_WAIT;
                ST_WAIT: if (data_here)          state_next = ST_HAVE;
                ST_HAVE: if (xfer && pc_reg[2])  state_next = ST_REQ;
                default:                         state_next = ST_REQ;
            endcase
        end
    end

    // Output and datapath next values for the registered outputs
    always_comb begin
        pc_next       = pc_reg;
        block_hi_next = block_hi_reg;
        cnt_next      = cnt_reg;
        rd_next       = 1'b0;
        addr_next     = addr_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;

        case (state_reg)
            ST_REQ: begin
                if (bus.wait_n) begin
                    rd_next   = 1'b1;
                    addr_next = pc_reg[ADDR_SZ+2:3];
                    cnt_next  = LAT;
                end
            end
            ST_WAIT: begin
                // The counter runs independently of wait_n; data is taken
                // in the cycle it reaches zero.
                if (data_here) begin
                    block_hi_next = bus.din_bus_a[INTEGER_SZ-1 -: INSTRUCTION_SZ];
                    instr_next    = pc_reg[2] ? bus.din_bus_a[INTEGER_SZ-1 -: INSTRUCTION_SZ]
                                              : bus.din_bus_a[INSTRUCTION_SZ-1:0];
                    instr_pc_next = pc_reg;
                    valid_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ST_HAVE: begin
                if (xfer) begin
                    pc_next = pc_reg + INTEGER_SZ'(4);
                    if (!pc_reg[2]) begin
                        // Second instruction of the same block: no memory access.
                        instr_next    = block_hi_reg;
                        instr_pc_next = pc_reg + INTEGER_SZ'(4);
                    end else begin
                        valid_next = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // A redirect wins over everything except reset. A transfer in the
        // same cycle still completes on the decode side; only the PC is replaced.
        if (bus.redirect) begin
            pc_next    = {bus.redirect_pc[INTEGER_SZ-1:2], 2'b00};
            valid_next = 1'b0;
            rd_next    = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg       <= RESET_PC;
            block_hi_reg <= '0;
            cnt_reg      <= '0;
            rd_reg       <= 1'b0;
            addr_reg     <= '0;
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            block_hi_reg <= block_hi_next;
            cnt_reg      <= cnt_next;
            rd_reg       <= rd_next;
            addr_reg     <= addr_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
        end
    end

    assign bus.rd_a        = rd_reg;
    assign bus.addr_bus_a  = addr_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
endmodule

// File: tb/tb_fisc_fetch_unit.sv
// Directed bench for fisc_fetch_unit. Instance A runs with RD_LATENCY=1,
// instance B with RD_LATENCY=3. Each has a small memory model that returns
// the addressed block only in the cycle RD_LATENCY after its rd_a pulse and
// a junk pattern otherwise.
module tb_fisc_fetch_unit;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic reset_n_a;
    logic reset_n_b;

    always #5 clk = ~clk;

    fisc_fetch_unit_if #(.INTEGER_SZ(64), .INSTRUCTION_SZ(32), .ADDR_SZ(16)) fa ();
    fisc_fetch_unit_if #(.INTEGER_SZ(64), .INSTRUCTION_SZ(32), .ADDR_SZ(16)) fb ();

    fisc_fetch_unit #(.RD_LATENCY(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n_a),
        .bus     (fa.master)
    );

    fisc_fetch_unit #(.RD_LATENCY(3)) dut_b (
        .clk     (clk),
        .reset_n (reset_n_b),
        .bus     (fb.master)
    );

    // Memory: blk0 = BBBB0002_AAAA0001, blk i = B10C0100+i : B10C0000+i.
    logic [63:0] mem [16];
    logic [7:0]  hist_a = '0;
    logic [7:0]  hist_b = '0;
    logic [3:0]  cap_a  = '0;
    logic [3:0]  cap_b  = '0;

    always @(posedge clk) begin
        hist_a <= {hist_a[6:0], fa.rd_a};
        hist_b <= {hist_b[6:0], fb.rd_a};
        if (fa.rd_a) cap_a <= fa.addr_bus_a[3:0];
        if (fb.rd_a) cap_b <= fb.addr_bus_a[3:0];
    end

    assign fa.din_bus_a = hist_a[0] ? mem[cap_a] : JUNK;
    assign fb.din_bus_a = hist_b[2] ? mem[cap_b] : JUNK;

    // One line per accepted instruction
    always @(posedge clk) begin
        if (fa.instr_valid && fa.instr_ready && fa.wait_n)
            $display("xfer A pc=0x%0h instr=0x%08h", fa.instr_pc, fa.instr);
        if (fb.instr_valid && fb.instr_ready && fb.wait_n)
            $display("xfer B pc=0x%0h instr=0x%08h", fb.instr_pc, fb.instr);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic [31:0] ins, input logic [63:0] pc);
        check_value({tag, " valid"}, fa.instr_valid, v);
        check_value({tag, " instr"}, fa.instr, ins);
        check_value({tag, " pc"},    fa.instr_pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 64'hBBBB0002_AAAA0001;
        for (int i = 1; i < 16; i++)
            mem[i] = {32'hB10C_0100 + 32'(i), 32'hB10C_0000 + 32'(i)};

        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        fa.wait_n = 1'b1; fa.redirect = 1'b0; fa.redirect_pc = '0; fa.instr_ready = 1'b1;
        fb.wait_n = 1'b1; fb.redirect = 1'b0; fb.redirect_pc = '0; fb.instr_ready = 1'b1;

        // Reset state
        #2;
        check_value("rst rd_a",  fa.rd_a, 0);
        check_value("rst addr",  fa.addr_bus_a, 0);
        check_a("rst", 1'b0, 32'h0, 64'h0);

        // Test 1: fetch from reset, two instructions back to back
        tick(); reset_n_a = 1'b1;                                   // REQ
        tick();
        check_value("t1 rd pulse", fa.rd_a, 1);
        check_value("t1 addr0",    fa.addr_bus_a, 0);
        check_value("t1 valid0",   fa.instr_valid, 0);
        tick();
        check_value("t1 rd single", fa.rd_a, 0);
        check_value("t1 valid wait", fa.instr_valid, 0);
        tick();
        check_a("t1 lo", 1'b1, 32'hAAAA0001, 64'h0);
        tick();
        check_a("t1 hi", 1'b1, 32'hBBBB0002, 64'h4);
        check_value("t1 no rd hi", fa.rd_a, 0);
        tick();
        check_value("t1 drop valid", fa.instr_valid, 0);
        check_value("t1 rd idle",    fa.rd_a, 0);
        tick();
        check_value("t1 rd blk1",   fa.rd_a, 1);
        check_value("t1 addr1",     fa.addr_bus_a, 1);
        tick();
        check_value("t2 valid wait", fa.instr_valid, 0);
        tick();
        check_a("t2 blk1 lo", 1'b1, 32'hB10C0001, 64'h8);

        // Test 2: decode stalls, outputs hold
        fa.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("t2 stall", 1'b1, 32'hB10C0001, 64'h8);
            check_value("t2 stall rd", fa.rd_a, 0);
        end
        fa.instr_ready = 1'b1;
        tick();
        check_a("t2 one xfer", 1'b1, 32'hB10C0101, 64'hC);
        fa.instr_ready = 1'b0;
        tick();
        check_a("t2 held", 1'b1, 32'hB10C0101, 64'hC);

        // Test 4: wait_n gates transfer and read issue, but not data capture
        fa.instr_ready = 1'b1; fa.wait_n = 1'b0;
        tick();
        check_a("t4 no xfer", 1'b1, 32'hB10C0101, 64'hC);
        fa.wait_n = 1'b1;
        tick();
        check_value("t4 exhausted", fa.instr_valid, 0);
        fa.wait_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("t4 req held rd", fa.rd_a, 0);
        end
        fa.wait_n = 1'b1;
        tick();
        check_value("t4 rd blk2", fa.rd_a, 1);
        check_value("t4 addr2",   fa.addr_bus_a, 2);
        fa.wait_n = 1'b0;
        tick();
        check_value("t4 wait valid", fa.instr_valid, 0);
        tick();
        check_a("t4 latched", 1'b1, 32'hB10C0002, 64'h10);
        tick();
        check_a("t4 gated", 1'b1, 32'hB10C0002, 64'h10);
        fa.wait_n = 1'b1;
        tick();
        check_a("t4 released", 1'b1, 32'hB10C0102, 64'h14);

        // Test 5: redirect (with simultaneous transfer) to the top block, then wrap
        fa.redirect = 1'b1; fa.redirect_pc = 64'h7FFFF;
        tick();
        check_value("t5 redir valid", fa.instr_valid, 0);
        check_value("t5 redir rd",    fa.rd_a, 0);
        fa.redirect = 1'b0;
        tick();
        check_value("t5 rd top",   fa.rd_a, 1);
        check_value("t5 addr top", fa.addr_bus_a, 16'hFFFF);
        tick();
        tick();
        check_a("t5 top hi", 1'b1, 32'hB10C010F, 64'h7FFFC);
        tick();
        check_value("t5 exhausted", fa.instr_valid, 0);
        tick();
        check_value("t5 rd wrap",   fa.rd_a, 1);
        check_value("t5 addr wrap", fa.addr_bus_a, 0);
        tick();
        tick();
        check_a("t5 wrap lo", 1'b1, 32'hAAAA0001, 64'h80000);
        tick();
        check_a("t5 wrap hi", 1'b1, 32'hBBBB0002, 64'h80004);
        tick();
        tick();
        check_value("t6 rd blk", fa.rd_a, 1);
        check_value("t6 addr1",  fa.addr_bus_a, 1);

        // Test 6: asynchronous reset in the middle of WAIT
        tick();
        #2 reset_n_a = 1'b0;
        #1;
        check_value("t6 async rd",   fa.rd_a, 0);
        check_value("t6 async addr", fa.addr_bus_a, 0);
        check_a("t6 async", 1'b0, 32'h0, 64'h0);
        tick(); reset_n_a = 1'b1;
        tick();
        check_value("t6 refetch rd",   fa.rd_a, 1);
        check_value("t6 refetch addr", fa.addr_bus_a, 0);
        tick();
        tick();
        check_a("t6 refetch", 1'b1, 32'hAAAA0001, 64'h0);

        // Test 3: redirect to 0x1E while a latency-3 read is in flight
        reset_n_b = 1'b1;
        tick();
        check_value("t3 rd blk0",  fb.rd_a, 1);
        check_value("t3 addr0",    fb.addr_bus_a, 0);
        tick();
        fb.redirect = 1'b1; fb.redirect_pc = 64'h1E;
        tick();
        check_value("t3 redir valid", fb.instr_valid, 0);
        check_value("t3 redir rd",    fb.rd_a, 0);
        fb.redirect = 1'b0;
        tick();
        check_value("t3 rd blk3", fb.rd_a, 1);
        check_value("t3 addr3",   fb.addr_bus_a, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t3 old data ignored", fb.instr_valid, 0);
        end
        tick();
        check_value("t3 valid",  fb.instr_valid, 1);
        check_value("t3 instr",  fb.instr, 32'hB10C0103);
        check_value("t3 pc",     fb.instr_pc, 64'h1C);
        tick();
        check_value("t3 exhausted", fb.instr_valid, 0);
        tick();
        check_value("t3 rd blk4", fb.rd_a, 1);
        check_value("t3 addr4",   fb.addr_bus_a, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
